// File: rtl/fft_frame_piso_if.sv
// Frame-load and serial-sample bundle between a frame producer and fft_frame_piso.
// The master loads frames; the slave streams samples to the FFT core.
interface fft_frame_piso_if #(
    parameter int FFT_SIZE = 32,
    parameter int IN_WIDTH = 12
);
    logic                         load;
    logic [FFT_SIZE*IN_WIDTH-1:0] frame_r;
    logic [FFT_SIZE*IN_WIDTH-1:0] frame_i;
    logic                         ready;
    logic                         in_valid;
    logic [IN_WIDTH-1:0]          din_r;
    logic [IN_WIDTH-1:0]          din_i;
    logic                         busy;
    logic                         done;
    logic                         overrun;

    modport master (
        output load, frame_r, frame_i,
        input  ready, in_valid, din_r, din_i, busy, done, overrun
    );

    modport slave (
        input  load, frame_r, frame_i,
        output ready, in_valid, din_r, din_i, busy, done, overrun
    );
endinterface

// File: rtl/fft_frame_piso.sv
// Parallel-in/serial-out frame feeder for the FFT core: one frame captured per load,
// streamed one complex sample per clock, with a one-deep pending frame and guard gap.
module fft_frame_piso #(
    parameter int FFT_SIZE   = 32,
    parameter int IN_WIDTH   = 12,
    parameter int GAP_CYCLES = 1
) (
    input logic              clk,
    input logic              rst,
    fft_frame_piso_if.slave  bus
);
    localparam int FW = FFT_SIZE * IN_WIDTH;
    localparam int IW = $clog2(FFT_SIZE);
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [GW-1:0] gap_cnt;
    logic [FW-1:0] act_r;
    logic [FW-1:0] act_i;
    logic [FW-1:0] pend_r;
    logic [FW-1:0] pend_i;
    logic          pend_valid;
    logic          last_idx;
    logic          last_gap;

    assign bus.ready = !pend_valid;
    assign last_idx  = (idx == IW'(FFT_SIZE - 1));
    assign last_gap  = (gap_cnt == GW'(GAP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            gap_cnt      <= '0;
            pend_valid   <= 1'b0;
            bus.in_valid <= 1'b0;
            bus.din_r    <= '0;
            bus.din_i    <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            bus.in_valid <= 1'b0;
            bus.din_r    <= '0;
            bus.din_i    <= '0;
            bus.done     <= 1'b0;
            // A full pending slot refuses the request, even on the edge that empties it.
            bus.overrun  <= bus.load && pend_valid;

            case (state)
                IDLE: begin
                    if (bus.load) begin
                        act_r    <= bus.frame_r;
                        act_i    <= bus.frame_i;
                        idx      <= '0;
                        state    <= SEND;
                        bus.busy <= 1'b1;
                    end
                end
                SEND: begin
                    bus.in_valid <= 1'b1;
                    bus.din_r    <= act_r[int'(idx)*IN_WIDTH +: IN_WIDTH];
                    bus.din_i    <= act_i[int'(idx)*IN_WIDTH +: IN_WIDTH];
                    idx          <= idx + 1'b1;
                    if (last_idx) begin
                        bus.done <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (last_gap) begin
                        if (pend_valid) begin
                            act_r      <= pend_r;
                            act_i      <= pend_i;
                            pend_valid <= 1'b0;
                            idx        <= '0;
                            state      <= SEND;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase

            // Capture and transfer are disjoint: capture needs the slot empty, transfer needs it full.
            if (state != IDLE && bus.load && !pend_valid) begin
                pend_r     <= bus.frame_r;
                pend_i     <= bus.frame_i;
                pend_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_piso.sv
// Directed bench for fft_frame_piso: table of single-frame patterns plus
// hand-written back-to-back, overrun, transfer-edge collision and mid-frame reset sequences.
module tb_fft_frame_piso;
    localparam int N  = 32;
    localparam int W  = 12;
    localparam int FW = N * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fft_frame_piso_if #(.FFT_SIZE(N), .IN_WIDTH(W)) bus ();

    fft_frame_piso #(.FFT_SIZE(N), .IN_WIDTH(W), .GAP_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pat;
        int first_r;
        int first_i;
        int last_r;
        int last_i;
    } vec_t;

    function automatic int pat_r(input int p, input int k);
        case (p)
            0:       return k;
            1:       return 100 + k;
            2:       return 500 + k;
            3:       return (k % 2 == 0) ? -2048 : 2047;
            4:       return -1000 + 64 * k;
            default: return 0;
        endcase
    endfunction

    function automatic int pat_i(input int p, input int k);
        case (p)
            0:       return -k;
            1:       return 100 + k;
            2:       return -500 - k;
            3:       return (k % 2 == 0) ? 2047 : -2048;
            4:       return 2047 - k;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input int p);
        logic [FW-1:0] fr;
        logic [FW-1:0] fi;
        for (int k = 0; k < N; k++) begin
            fr[k*W +: W] = W'(pat_r(p, k));
            fi[k*W +: W] = W'(pat_i(p, k));
        end
        bus.frame_r = fr;
        bus.frame_i = fi;
        bus.load    = 1'b1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.load = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_sample(input string tag, input int p, input int k);
        chk({tag, " in_valid"}, int'(bus.in_valid), 1);
        chk({tag, " din_r"}, int'($signed(bus.din_r)), pat_r(p, k));
        chk({tag, " din_i"}, int'($signed(bus.din_i)), pat_i(p, k));
        chk({tag, " done"}, int'(bus.done), (k == N - 1) ? 1 : 0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " in_valid"}, int'(bus.in_valid), 0);
        chk({tag, " din_r"}, int'(bus.din_r), 0);
        chk({tag, " din_i"}, int'(bus.din_i), 0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{pat: 0, first_r: 0,     first_i: 0,    last_r: 31,   last_i: -31};
        vecs[1] = '{pat: 3, first_r: -2048, first_i: 2047, last_r: 2047, last_i: -2048};
        vecs[2] = '{pat: 4, first_r: -1000, first_i: 2047, last_r: 984,  last_i: 2016};
        vecs[3] = '{pat: 1, first_r: 100,   first_i: 100,  last_r: 131,  last_i: 131};

        bus.load    = 1'b0;
        bus.frame_r = '0;
        bus.frame_i = '0;

        do_reset();
        check_quiet("reset");
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset overrun", int'(bus.overrun), 0);
        chk("reset ready", int'(bus.ready), 1);

        // Single frames from the table
        foreach (vecs[v]) begin
            do_reset();
            set_load(vecs[v].pat);
            step();
            bus.load = 1'b0;
            check_quiet("single load");
            chk("single busy rise", int'(bus.busy), 1);
            for (int k = 0; k < N; k++) begin
                step();
                check_sample("single", vecs[v].pat, k);
                if (k == 0) begin
                    chk("single first_r", int'($signed(bus.din_r)), vecs[v].first_r);
                    chk("single first_i", int'($signed(bus.din_i)), vecs[v].first_i);
                end
                if (k == N - 1) begin
                    chk("single last_r", int'($signed(bus.din_r)), vecs[v].last_r);
                    chk("single last_i", int'($signed(bus.din_i)), vecs[v].last_i);
                end
            end
            step();
            check_quiet("single gap");
            chk("single busy fall", int'(bus.busy), 0);
            chk("single ready", int'(bus.ready), 1);
        end

        // Back-to-back with a mid-frame overrun
        do_reset();
        set_load(0);
        step();
        bus.load = 1'b0;
        for (int k = 0; k < N; k++) begin
            step();
            check_sample("b2b A", 0, k);
            if (k == 10) set_load(1);
            if (k == 11) begin
                bus.load = 1'b0;
                chk("b2b ready drop", int'(bus.ready), 0);
                chk("b2b no overrun", int'(bus.overrun), 0);
            end
            if (k == 20) set_load(2);
            if (k == 21) begin
                bus.load = 1'b0;
                chk("ovr pulse", int'(bus.overrun), 1);
            end
            if (k == 22) chk("ovr single", int'(bus.overrun), 0);
        end
        step();
        check_quiet("b2b gap");
        chk("b2b gap busy", int'(bus.busy), 1);
        chk("b2b gap ready", int'(bus.ready), 1);
        for (int k = 0; k < N; k++) begin
            step();
            check_sample("b2b B", 1, k);
            chk("b2b B overrun", int'(bus.overrun), 0);
        end
        step();
        chk("b2b busy fall", int'(bus.busy), 0);
        for (int c = 0; c < 5; c++) begin
            step();
            check_quiet("ovr dropped");
        end

        // Load on the pending-to-active transfer edge
        do_reset();
        set_load(0);
        step();
        bus.load = 1'b0;
        for (int k = 0; k < N; k++) begin
            step();
            check_sample("coll A", 0, k);
            if (k == 5) set_load(1);
            if (k == 6) bus.load = 1'b0;
        end
        set_load(2);
        chk("coll ready low", int'(bus.ready), 0);
        step();
        bus.load = 1'b0;
        check_quiet("coll gap");
        chk("coll overrun", int'(bus.overrun), 1);
        chk("coll ready back", int'(bus.ready), 1);
        for (int k = 0; k < N; k++) begin
            step();
            check_sample("coll B", 1, k);
            if (k == 0) chk("coll overrun clear", int'(bus.overrun), 0);
        end
        step();
        chk("coll busy fall", int'(bus.busy), 0);
        for (int c = 0; c < 5; c++) begin
            step();
            check_quiet("coll dropped");
        end

        // Reset in the middle of a frame with a pending frame queued
        do_reset();
        set_load(0);
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            check_sample("rst A", 0, k);
            if (k == 5) set_load(1);
            if (k == 6) bus.load = 1'b0;
        end
        rst = 1'b1;
        set_load(2);
        step();
        rst      = 1'b0;
        bus.load = 1'b0;
        check_quiet("rst abort");
        chk("rst busy", int'(bus.busy), 0);
        chk("rst done", int'(bus.done), 0);
        chk("rst ready", int'(bus.ready), 1);
        for (int c = 0; c < 5; c++) begin
            step();
            check_quiet("rst no pending");
        end
        set_load(3);
        step();
        bus.load = 1'b0;
        for (int k = 0; k < N; k++) begin
            step();
            check_sample("rst fresh", 3, k);
        end
        step();
        check_quiet("rst fresh gap");
        chk("rst fresh busy", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_frame_piso.md
# fft_frame_piso

Parallel-in/serial-out frame feeder for the 32-point FFT core: the transmit-side counterpart of the output SIPO collectors. It captures a full frame of complex samples (real and imaginary lanes) in one cycle and streams it into the FFT core's serial `in_valid`/`din_r`/`din_i` port, one sample per clock. A one-deep pending buffer allows the next frame to be loaded while the current one is streaming, with a guard gap between frames.

## Interface
- `FFT_SIZE`, 32, samples per frame; power of two, at least 4
- `IN_WIDTH`, 12, signed sample width per lane
- `GAP_CYCLES`, 1, idle cycles (`in_valid`=0) forced after each frame; at least 1
- Clock is `clk`; reset is `rst`. Single clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `load`  in  1  capture request; frame buses sampled on the same edge
- `frame_r`  in  FFT_SIZE*IN_WIDTH  real lanes; sample k at `[k*IN_WIDTH +: IN_WIDTH]`
- `frame_i`  in  FFT_SIZE*IN_WIDTH  imaginary lanes, same packing
- `ready`  out  1  pending slot empty; `load` is accepted only when high
- `in_valid`  out  1  to FFT core; high while a sample is presented
- `din_r`  out  IN_WIDTH  signed real sample to FFT core
- `din_i`  out  IN_WIDTH  signed imaginary sample to FFT core
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse coinciding with the last sample of a frame
- `overrun`  out  1  one-cycle pulse, registered one cycle after a `load` arrives with `ready`=0

## Operation
- Storage: active buffer, plus a pending buffer with a `pend_valid` flag. Sample index counter `idx` is `$clog2(FFT_SIZE)` bits. Gap counter counts up to `GAP_CYCLES`.
- `ready` = `!pend_valid`. It is combinational and reads 1 immediately after reset.
- State IDLE
  - `load` copies the frame into the active buffer, sets `idx`=0, and goes to SEND.
  - `pend_valid` is never 1 in IDLE.
- State SEND
  - Each cycle, present active sample `idx` with `in_valid`=1, then increment `idx`.
  - At `idx`=FFT_SIZE-1, pulse `done` and go to GAP.
- State GAP
  - `in_valid`=0 for exactly `GAP_CYCLES` cycles.
  - On the last gap cycle with `pend_valid`=1: move pending to active, clear `pend_valid`, set `idx`=0, go to SEND.
  - Otherwise go to IDLE.
- `load` during SEND or GAP with `ready`=1 captures into the pending buffer and sets `pend_valid`.
- `load` with `ready`=0 is dropped and pulses `overrun`. Active and pending contents are unchanged.
- Simultaneous pending-to-active transfer and `load` in the same cycle: `ready` was 0, so the request is an overrun. The clearing of `pend_valid` does not admit it.
- When `in_valid`=0, `din_r`/`din_i` are driven to 0.
- Samples pass through bit-exact: no scaling, no reordering (natural order k=0..FFT_SIZE-1).

## Timing
- Reset values:
  - `in_valid`=0, `din_r`=0, `din_i`=0, `busy`=0, `done`=0, `overrun`=0
  - `pend_valid`=0, so `ready`=1 once `rst` is low
  - state IDLE, `idx`=0
- `rst` mid-frame aborts the stream: `in_valid` is low on the cycle after the reset edge. Pending data is discarded. A `load` on the reset edge is ignored.
- All outputs except `ready` are registered.
- Latency: with `load` sampled at edge t in IDLE, sample k appears after edge t+1+k. Samples occupy FFT_SIZE consecutive cycles with no bubbles. `done` is high with sample FFT_SIZE-1.
- Back-to-back frames: the first sample of the next frame appears exactly GAP_CYCLES+1 edges after the last sample of the previous frame.
- `busy` rises on the edge that accepts `load` from IDLE. It falls on the edge entering IDLE.

## Test plan
- **Single frame.** After reset, `load` with `frame_r` lane k = k and `frame_i` lane k = -k.
  - `in_valid` high for 32 consecutive cycles starting 1 cycle after `load`, carrying (0,0), (1,-1) … (31,-31).
  - `done` high with (31,-31); `busy` falls after the gap.
- **Back-to-back.** Second `load` (lanes = 100+k) during sample 10 of frame A.
  - `ready` drops.
  - Frame B starts 2 cycles after A's last sample (GAP_CYCLES=1) with value 100.
  - No `overrun`.
- **Overrun.** Third `load` while pending is full.
  - `overrun` pulses once.
  - Streamed frames A and B are unaltered; the third frame never appears.
- **Transfer-edge collision.** `load` on the last GAP cycle with pending full.
  - `overrun`=1; B streams normally; `ready` returns to 1 on the following cycle.
- **Mid-frame reset.** Assert `rst` at sample 15.
  - `in_valid`=0 and `din_r`/`din_i`=0 next cycle; `ready`=1; the pending frame is not sent.
  - A fresh `load` then streams from sample 0.
- **Sign extremes.** Lanes alternate -2048 and +2047: the output matches bit-exactly.
